monitor_matriz_leds: RTL and testbench
======================================

// Module: monitor_matriz_leds
// PURPOSE
//  Receive side of the 5x7 LED-matrix scan interface. Samples the multiplexed column strobes and row data
//  driven to the matrix and rebuilds the displayed frame as five 7-bit column words. Supports on-board
//  self-check and the bench scoreboard: the rebuilt frame must equal the selected/attack map.
//  Sits beside the matrix driver, on the same clock, tapping c0..c4 / l0..l6.
// PARAMETERS
//  STABLE_CYCLES   4      consecutive identical synced samples before a column event is accepted (>=2)
//  TIMEOUT_CYCLES  65536  cycles with no accepted column event before scan_active drops
//  TO_W            17     timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clock_in     in   1   system clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  col_n        in   5   column strobes {c4..c0}, active-low, one-hot low when a column is lit
//  row          in   7   row data {l6..l0}, active-high, valid while a column is low
//  clear_err    in   1   synchronous clear of both sticky error flags
//  frame0..4    out  7   last complete frame, column k in framek (bit i = row i)
//  frame_valid  out  1   one-cycle pulse when frame0..4 update
//  frame_count  out  8   complete frames received, wraps 255->0
//  scan_active  out  1   1 = scan seen recently, 0 = matrix off/stalled
//  err_multi_col out 1   sticky: accepted pattern had >1 column low
//  err_order    out  1   sticky: accepted column out of 0,1,2,3,4 sequence
// BEHAVIOUR
//  Reset: all outputs 0, shadow buffer 0, FSM=HUNT, expect=0, counters 0. Async assert, sync release.
//  Input path: col_n,row through 2-FF synchronisers (2 cycles latency).
//  Stability gate: stable_cnt clears when synced {col_n,row} differs from previous cycle, else increments
//   (saturating). Accept fires exactly once per stable period, on the cycle stable_cnt reaches STABLE_CYCLES-1.
//  Decode of accepted pattern: all ones = blank, no action, no error; one zero at bit k = column k;
//   more than one zero = set err_multi_col, FSM->HUNT, shadow unchanged.
//  FSM HUNT: column 0 -> shadow[0]=row, expect=1, ->CAPTURE; any other column ignored, no error.
//  FSM CAPTURE: column==expect -> shadow[k]=row, expect++; if k==4: commit shadow->frame0..4 and
//   pulse frame_valid on the next edge, frame_count++, scan_active=1, expect=0, stay CAPTURE.
//   Column!=expect -> set err_order; if column==0 restart (shadow[0]=row, expect=1) else ->HUNT.
//  Latency: col4 pin edge to frame_valid = 2 + STABLE_CYCLES + 1 cycles with a steady input.
//  Repeated column without an intervening change is only accepted once (gate); a column re-lit after
//   a blank but out of sequence is an order error.
//  Timeout: to_cnt clears on each accepted column event (not blank); counts otherwise, saturating.
//   At TIMEOUT_CYCLES: scan_active=0, FSM->HUNT, expect=0; frame0..4 and frame_count retained.
//  clear_err: clears both flags next edge; a new error on the same cycle wins (flag stays 1).
//  frame_valid never asserts in the same cycle as reset release; outputs change only on commit.
//  Reset mid-frame: partial shadow discarded, frame outputs return to 0.
// TESTING
//  1 Reset: hold reset_n=0 with random inputs -> all outputs 0; release -> remain 0, FSM HUNT.
//  2 Clean scan: cols 0..4 then blank, each 8 cycles, rows 01,02,04,08,10 -> frame0..4 = those values,
//    one frame_valid pulse 7 cycles after col4 applied, frame_count=1, scan_active=1.
//  3 Glitch: col_n=11110 held 2 cycles between blanks -> no capture, no error, frame_count unchanged.
//  4 col_n=11100 for 8 cycles -> err_multi_col=1, no frame_valid; clear_err pulse -> 0 next cycle.
//  5 Order: cols 0,1,3 -> err_order=1, HUNT; following full 0..4 scan -> frame_valid, correct frame.
//  6 TIMEOUT_CYCLES=64: complete frame, then blank -> scan_active falls 64 cycles after col4 accept,
//    frame held; 256 frames -> frame_count wraps to 0; reset asserted during col2 -> all outputs 0.

Source files
------------

// File: rtl/monitor_matriz_leds.sv
// monitor_matriz_leds: rebuilds the 5x7 LED-matrix frame from sampled column strobes and row data.
module monitor_matriz_leds #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TO_W           = 17
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic [4:0] col_n,
  input  logic [6:0] row,
  input  logic       clear_err,
  output logic [6:0] frame0,
  output logic [6:0] frame1,
  output logic [6:0] frame2,
  output logic [6:0] frame3,
  output logic [6:0] frame4,
  output logic       frame_valid,
  output logic [7:0] frame_count,
  output logic       scan_active,
  output logic       err_multi_col,
  output logic       err_order
);
  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  typedef enum logic {HUNT, CAPTURE} state_t;
  logic [1:0] rst_sync_q;
  logic rst_n;
  logic [4:0] col_meta_q, col_meta_d, col_sync_q, col_sync_d, col_prev_q, col_prev_d, acc_col_q, acc_col_d;
  logic [6:0] row_meta_q, row_meta_d, row_sync_q, row_sync_d, row_prev_q, row_prev_d, acc_row_q, acc_row_d;
  logic [SW-1:0] stable_q, stable_d;
  logic accept_q, accept_d, same;
  state_t state_q, state_d;
  logic [2:0] exp_col_q, exp_col_d, k;
  logic [4:0][6:0] shadow_q, shadow_d, frame_q, frame_d;
  logic frame_valid_q, frame_valid_d, scan_q, scan_d;
  logic err_multi_q, err_multi_d, err_order_q, err_order_d;
  logic [7:0] count_q, count_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [4:0] zeros;
  logic single, multi;
  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clock_in or negedge reset_n)
    if (!reset_n) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  always_comb begin
    col_meta_d = col_n;
    row_meta_d = row;
    col_sync_d = col_meta_q;
    row_sync_d = row_meta_q;
    col_prev_d = col_sync_q;
    row_prev_d = row_sync_q;
    same = {col_sync_q, row_sync_q} == {col_prev_q, row_prev_q};
    stable_d = !same ? '0 : (stable_q == SW'(STABLE_CYCLES - 1) ? stable_q : stable_q + 1'b1);
    accept_d = same && stable_q == SW'(STABLE_CYCLES - 2);
    acc_col_d = col_sync_q;
    acc_row_d = row_sync_q;
  end
  always_comb begin
    zeros = ~acc_col_q;
    single = $countones(zeros) == 1;
    multi = $countones(zeros) > 1;
    k = '0;
    for (int i = 0; i < 5; i++) if (zeros[i]) k = 3'(i);
  end
  always_comb begin
    state_d = state_q;
    exp_col_d = exp_col_q;
    shadow_d = shadow_q;
    frame_d = frame_q;
    frame_valid_d = 1'b0;
    count_d = count_q;
    scan_d = scan_q;
    err_multi_d = err_multi_q & ~clear_err;
    err_order_d = err_order_q & ~clear_err;
    to_d = (accept_q && single) ? '0 : (to_q == TO_W'(TIMEOUT_CYCLES) ? to_q : to_q + 1'b1);
    if (accept_q && multi) begin
      err_multi_d = 1'b1;
      state_d = HUNT;
      exp_col_d = '0;
    end else if (accept_q && single) begin
      if (state_q == HUNT) begin
        if (k == 3'd0) begin
          shadow_d[0] = acc_row_q;
          exp_col_d = 3'd1;
          state_d = CAPTURE;
        end
      end else if (k == exp_col_q) begin
        shadow_d[k] = acc_row_q;
        exp_col_d = exp_col_q + 3'd1;
        if (k == 3'd4) begin
          frame_d = shadow_d;
          frame_valid_d = 1'b1;
          count_d = count_q + 8'd1;
          scan_d = 1'b1;
          exp_col_d = '0;
        end
      end else begin
        err_order_d = 1'b1;
        if (k == 3'd0) begin
          shadow_d[0] = acc_row_q;
          exp_col_d = 3'd1;
        end else begin
          state_d = HUNT;
          exp_col_d = '0;
        end
      end
    end
    if (to_d == TO_W'(TIMEOUT_CYCLES)) begin
      scan_d = 1'b0;
      state_d = HUNT;
      exp_col_d = '0;
    end
  end
  always_ff @(posedge clock_in or negedge rst_n)
    if (!rst_n) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
      col_prev_q <= '1;
      acc_col_q <= '1;
      row_meta_q <= '0;
      row_sync_q <= '0;
      row_prev_q <= '0;
      acc_row_q <= '0;
      stable_q <= '0;
      accept_q <= 1'b0;
      state_q <= HUNT;
      exp_col_q <= '0;
      shadow_q <= '0;
      frame_q <= '0;
      frame_valid_q <= 1'b0;
      count_q <= '0;
      scan_q <= 1'b0;
      err_multi_q <= 1'b0;
      err_order_q <= 1'b0;
      to_q <= '0;
    end else begin
      col_meta_q <= col_meta_d;
      col_sync_q <= col_sync_d;
      col_prev_q <= col_prev_d;
      acc_col_q <= acc_col_d;
      row_meta_q <= row_meta_d;
      row_sync_q <= row_sync_d;
      row_prev_q <= row_prev_d;
      acc_row_q <= acc_row_d;
      stable_q <= stable_d;
      accept_q <= accept_d;
      state_q <= state_d;
      exp_col_q <= exp_col_d;
      shadow_q <= shadow_d;
      frame_q <= frame_d;
      frame_valid_q <= frame_valid_d;
      count_q <= count_d;
      scan_q <= scan_d;
      err_multi_q <= err_multi_d;
      err_order_q <= err_order_d;
      to_q <= to_d;
    end
  assign frame0 = frame_q[0];
  assign frame1 = frame_q[1];
  assign frame2 = frame_q[2];
  assign frame3 = frame_q[3];
  assign frame4 = frame_q[4];
  assign frame_valid = frame_valid_q;
  assign frame_count = count_q;
  assign scan_active = scan_q;
  assign err_multi_col = err_multi_q;
  assign err_order = err_order_q;
endmodule

// File: tb/tb_monitor_matriz_leds.sv
// tb_monitor_matriz_leds: directed checks of frame rebuild, gating, errors, timeout and reset.
module tb_monitor_matriz_leds;
  logic clock_in = 1'b0, reset_n = 1'b0, clear_err = 1'b0;
  logic [4:0] col_n = '1;
  logic [6:0] row = '0;
  logic [6:0] frame0, frame1, frame2, frame3, frame4;
  logic frame_valid, scan_active, err_multi_col, err_order;
  logic [7:0] frame_count;
  logic [34:0] frame;
  logic [46:0] outs;
  int checks = 0, failures = 0, fv_seen = 0, base;
  monitor_matriz_leds #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64), .TO_W(17)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .col_n(col_n), .row(row), .clear_err(clear_err),
    .frame0(frame0), .frame1(frame1), .frame2(frame2), .frame3(frame3), .frame4(frame4),
    .frame_valid(frame_valid), .frame_count(frame_count), .scan_active(scan_active),
    .err_multi_col(err_multi_col), .err_order(err_order)
  );
  always #5 clock_in = ~clock_in;
  always @(negedge clock_in) if (frame_valid) fv_seen++;
  assign frame = {frame4, frame3, frame2, frame1, frame0};
  assign outs = {frame, frame_valid, frame_count, scan_active, err_multi_col, err_order};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask
  task automatic drive(input int c, input logic [6:0] r);
    col_n = (c < 0) ? 5'h1f : ~(5'b00001 << c);
    row = r;
  endtask
  task automatic scan(input logic [34:0] rows, input int n);
    for (int c = 0; c < 5; c++) begin
      drive(c, rows[c*7 +: 7]);
      step(n);
    end
  endtask
  initial begin
    for (int i = 0; i < 5; i++) begin
      col_n = 5'($urandom);
      row = 7'($urandom);
      step(1);
    end
    check("reset_outs", outs, '0);
    drive(-1, '0);
    reset_n = 1'b1;
    step(6);
    check("release_outs", outs, '0);
    for (int c = 0; c < 4; c++) begin
      drive(c, 7'(1 << c));
      step(8);
    end
    drive(4, 7'h10);
    step(6);
    check("fv_early", frame_valid, 1'b0);
    step(1);
    check("fv_latency", frame_valid, 1'b1);
    step(1);
    check("fv_one_cycle", frame_valid, 1'b0);
    drive(-1, '0);
    step(8);
    check("clean_frame", frame, {7'h10, 7'h08, 7'h04, 7'h02, 7'h01});
    check("clean_count", frame_count, 8'd1);
    check("clean_scan", scan_active, 1'b1);
    check("clean_fv_seen", fv_seen, 1);
    drive(0, 7'h7f);
    step(2);
    drive(-1, '0);
    step(8);
    check("glitch_count", frame_count, 8'd1);
    check("glitch_errs", {err_multi_col, err_order}, 2'b00);
    check("glitch_fv", fv_seen, 1);
    col_n = 5'b11100;
    step(8);
    drive(-1, '0);
    step(8);
    check("multi_err", err_multi_col, 1'b1);
    check("multi_fv", fv_seen, 1);
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    check("multi_clear", err_multi_col, 1'b0);
    drive(0, 7'h7f);
    step(8);
    drive(1, 7'h55);
    step(8);
    drive(3, 7'h2a);
    step(8);
    check("order_err", err_order, 1'b1);
    scan({7'h55, 7'h44, 7'h33, 7'h22, 7'h11}, 8);
    drive(-1, '0);
    step(8);
    check("order_frame", frame, {7'h55, 7'h44, 7'h33, 7'h22, 7'h11});
    check("order_count", frame_count, 8'd2);
    check("order_fv", fv_seen, 2);
    for (int c = 0; c < 4; c++) begin
      drive(c, 7'(7'h41 + c));
      step(8);
    end
    drive(4, 7'h45);
    step(7);
    check("to_fv", frame_valid, 1'b1);
    step(1);
    drive(-1, '0);
    step(62);
    check("to_scan_before", scan_active, 1'b1);
    step(1);
    check("to_scan_after", scan_active, 1'b0);
    check("to_frame_held", frame, {7'h45, 7'h44, 7'h43, 7'h42, 7'h41});
    check("to_count_held", frame_count, 8'd3);
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(4);
    base = fv_seen;
    repeat (256) scan({7'h0f, 7'h1e, 7'h3c, 7'h78, 7'h71}, 5);
    drive(-1, '0);
    step(8);
    check("wrap_count", frame_count, 8'd0);
    check("wrap_fv", fv_seen - base, 256);
    check("wrap_frame", frame, {7'h0f, 7'h1e, 7'h3c, 7'h78, 7'h71});
    drive(0, 7'h01);
    step(8);
    drive(1, 7'h02);
    step(8);
    drive(2, 7'h04);
    step(3);
    reset_n = 1'b0;
    #1;
    check("midframe_reset", outs, '0);
    reset_n = 1'b1;
    drive(-1, '0);
    step(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
